// File: rtl/card_anim_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | card_anim_pkg                                                        |
// | Shared types and constants for the card deal animation stage.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package card_anim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        LAND = 2'd2
    } anim_state_t;

    localparam int CARD_W    = 56;
    localparam int CARD_H    = 80;
    localparam int DECK_XPOS = 252;
    localparam int DECK_YPOS = 365;
    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;

    localparam logic [11:0] TRANSPARENT_RGB = 12'hF0F;

    function automatic logic [10:0] clamp_coord(input logic [10:0] val, input logic [10:0] lim);
        return (val > lim) ? lim : val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_if                                                               |
// | VGA timing and colour bundle passed between pipeline stages.         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/card_pos_stepper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | card_pos_stepper                                                     |
// | One-axis mover: steps cur toward tgt by min(STEP,|diff|) on a tick.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module card_pos_stepper #(
    parameter int STEP = 4,
    parameter int W    = 11
) (
    input  logic [W-1:0] i_cur,
    input  logic [W-1:0] i_tgt,
    input  logic         i_tick,
    output logic [W-1:0] o_nxt,
    output logic         o_arrived
);

    localparam logic [W-1:0] c_step = W'(STEP);

    logic         w_up;
    logic [W-1:0] w_diff;
    logic [W-1:0] w_amt;

    always_comb begin
        w_up   = (i_tgt >= i_cur);
        w_diff = w_up ? (i_tgt - i_cur) : (i_cur - i_tgt);
        w_amt  = (w_diff > c_step) ? c_step : w_diff;
        o_nxt  = i_cur;
        if (i_tick) begin
            o_nxt = w_up ? (i_cur + w_amt) : (i_cur - w_amt);
        end
    end

    assign o_arrived = (o_nxt == i_tgt);

endmodule
`default_nettype wire

// File: rtl/delay.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | delay                                                                |
// | Generic WIDTH-bit shift register of CLK_DEL clocks, async clear.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module delay #(
    parameter int WIDTH   = 8,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (CLK_DEL == 0) begin : g_pass
            assign o_data = i_data;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [CLK_DEL];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < CLK_DEL; i++) r_stage[i] <= '0;
                end else begin
                    r_stage[0] <= i_data;
                    for (int i = 1; i < CLK_DEL; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_data = r_stage[CLK_DEL-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/card_deal_anim.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | card_deal_anim                                                       |
// | Slides a face-down card sprite from the deck to a table slot, one    |
// | step per frame, overlaying ROM pixels on the VGA stream.             |
// | Option: CARD_ANIM_TRANSPARENT_EN makes ROM colour 12'hF0F see-through.|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module card_deal_anim #(
    parameter int DECK_XPOS = card_anim_pkg::DECK_XPOS,
    parameter int DECK_YPOS = card_anim_pkg::DECK_YPOS,
    parameter int CARD_W    = card_anim_pkg::CARD_W,
    parameter int CARD_H    = card_anim_pkg::CARD_H,
    parameter int STEP      = 4,
    parameter int ROM_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        deal_req,
    input  logic [10:0] target_x,
    input  logic [10:0] target_y,
    output logic        deal_ack,
    output logic        busy,
    output logic        done,
    input  logic [11:0] rgb_pixel,
    output logic [12:0] pixel_addr,
    vga_if.in           vga_in,
    vga_if.out          vga_out
);

    import card_anim_pkg::*;

    localparam logic [10:0] c_deck_x = 11'(DECK_XPOS);
    localparam logic [10:0] c_deck_y = 11'(DECK_YPOS);
    localparam logic [10:0] c_card_w = 11'(CARD_W);
    localparam logic [10:0] c_card_h = 11'(CARD_H);
    localparam logic [10:0] c_max_x  = 11'(SCREEN_W - CARD_W);
    localparam logic [10:0] c_max_y  = 11'(SCREEN_H - CARD_H);
    localparam int          c_pipe_w = 39;

    anim_state_t r_state, w_state_nxt;
    logic [10:0] r_pos_x, r_pos_y, w_pos_x_nxt, w_pos_y_nxt;
    logic [10:0] r_tgt_x, r_tgt_y, w_tgt_x_nxt, w_tgt_y_nxt;
    logic [10:0] w_step_x, w_step_y;
    logic        w_arr_x, w_arr_y;
    logic        r_vblnk_prev, w_tick;
    logic        r_deal_ack, w_deal_ack_nxt;
    logic        r_done, w_done_nxt;

    assign w_tick = vga_in.vblnk & ~r_vblnk_prev;

    card_pos_stepper #(.STEP(STEP), .W(11)) u_step_x (
        .i_cur     (r_pos_x),
        .i_tgt     (r_tgt_x),
        .i_tick    (w_tick),
        .o_nxt     (w_step_x),
        .o_arrived (w_arr_x)
    );

    card_pos_stepper #(.STEP(STEP), .W(11)) u_step_y (
        .i_cur     (r_pos_y),
        .i_tgt     (r_tgt_y),
        .i_tick    (w_tick),
        .o_nxt     (w_step_y),
        .o_arrived (w_arr_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pos_x      <= c_deck_x;
            r_pos_y      <= c_deck_y;
            r_tgt_x      <= c_deck_x;
            r_tgt_y      <= c_deck_y;
            r_vblnk_prev <= 1'b0;
            r_deal_ack   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pos_x      <= w_pos_x_nxt;
            r_pos_y      <= w_pos_y_nxt;
            r_tgt_x      <= w_tgt_x_nxt;
            r_tgt_y      <= w_tgt_y_nxt;
            r_vblnk_prev <= vga_in.vblnk;
            r_deal_ack   <= w_deal_ack_nxt;
            r_done       <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pos_x_nxt    = r_pos_x;
        w_pos_y_nxt    = r_pos_y;
        w_tgt_x_nxt    = r_tgt_x;
        w_tgt_y_nxt    = r_tgt_y;
        w_deal_ack_nxt = 1'b0;
        w_done_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                if (deal_req) begin
                    w_tgt_x_nxt    = clamp_coord(target_x, c_max_x);
                    w_tgt_y_nxt    = clamp_coord(target_y, c_max_y);
                    w_pos_x_nxt    = c_deck_x;
                    w_pos_y_nxt    = c_deck_y;
                    w_deal_ack_nxt = 1'b1;
                    w_state_nxt    = MOVE;
                end
            end
            MOVE: begin
                if (w_tick) begin
                    w_pos_x_nxt = w_step_x;
                    w_pos_y_nxt = w_step_y;
                    if (w_arr_x && w_arr_y) w_state_nxt = LAND;
                end
            end
            LAND: begin
                if (w_tick) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign deal_ack = r_deal_ack;
    assign done     = r_done;
    assign busy     = (r_state != IDLE);

    // Window decode runs on the undelayed stream so the ROM has ROM_LAT clocks to answer.
    logic [10:0] w_dx, w_dy;
    logic        w_in_x, w_in_y, w_in_window;

    assign w_dx        = vga_in.hcount - r_pos_x;
    assign w_dy        = vga_in.vcount - r_pos_y;
    assign w_in_x      = (vga_in.hcount >= r_pos_x) && (w_dx < c_card_w);
    assign w_in_y      = (vga_in.vcount >= r_pos_y) && (w_dy < c_card_h);
    assign w_in_window = busy && w_in_x && w_in_y;
    assign pixel_addr  = w_in_window ? 13'(int'(w_dy) * CARD_W + int'(w_dx)) : 13'd0;

    logic [c_pipe_w-1:0] w_pipe_in, w_pipe_out;
    logic                w_flag_d;
    logic [10:0]         w_hcount_d, w_vcount_d;
    logic                w_hsync_d, w_vsync_d, w_hblnk_d, w_vblnk_d;
    logic [11:0]         w_rgb_d;
    logic                w_use_rom;

    assign w_pipe_in = {w_in_window, vga_in.hcount, vga_in.vcount, vga_in.hsync,
                        vga_in.vsync, vga_in.hblnk, vga_in.vblnk, vga_in.rgb};

    delay #(.WIDTH(c_pipe_w), .CLK_DEL(ROM_LAT)) u_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (w_pipe_in),
        .o_data (w_pipe_out)
    );

    assign {w_flag_d, w_hcount_d, w_vcount_d, w_hsync_d,
            w_vsync_d, w_hblnk_d, w_vblnk_d, w_rgb_d} = w_pipe_out;

`ifdef CARD_ANIM_TRANSPARENT_EN
    assign w_use_rom = w_flag_d && (rgb_pixel != TRANSPARENT_RGB);
`else
    assign w_use_rom = w_flag_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.hcount <= w_hcount_d;
            vga_out.vcount <= w_vcount_d;
            vga_out.hsync  <= w_hsync_d;
            vga_out.vsync  <= w_vsync_d;
            vga_out.hblnk  <= w_hblnk_d;
            vga_out.vblnk  <= w_vblnk_d;
            vga_out.rgb    <= w_use_rom ? rgb_pixel : w_rgb_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_card_deal_anim.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_card_deal_anim                                                    |
// | Directed bench for card_deal_anim with a 2-clock ROM model.          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_card_deal_anim;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        deal_req;
    logic [10:0] target_x, target_y;
    logic        deal_ack, busy, done;
    logic [11:0] rgb_pixel;
    logic [12:0] pixel_addr;

    vga_if vin ();
    vga_if vout ();

    card_deal_anim dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .deal_req   (deal_req),
        .target_x   (target_x),
        .target_y   (target_y),
        .deal_ack   (deal_ack),
        .busy       (busy),
        .done       (done),
        .rgb_pixel  (rgb_pixel),
        .pixel_addr (pixel_addr),
        .vga_in     (vin),
        .vga_out    (vout)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_f(input logic [12:0] a);
        return a[11:0] ^ 12'h5A5;
    endfunction

    logic [11:0] rom_s1;
    logic        rom_force = 1'b0;
    always @(posedge clk) begin
        rom_s1    <= rom_force ? 12'hF0F : rom_f(pixel_addr);
        rgb_pixel <= rom_s1;
    end

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic [11:0] bg;
        logic [12:0] exp_addr;
        logic        exp_in;
    } probe_t;

    probe_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n, output int n_done);
        n_done = 0;
        for (int i = 0; i < n; i++) begin
            vin.vblnk = 1'b1;
            clk_step();
            if (done) n_done++;
            vin.vblnk = 1'b0;
            clk_step();
            if (done) n_done++;
        end
    endtask

    task automatic start_deal(input string name, input logic [10:0] tx, input logic [10:0] ty, input bit hold);
        deal_req = 1'b1;
        target_x = tx;
        target_y = ty;
        clk_step();
        check({name, " ack"}, deal_ack, 1);
        check({name, " busy"}, busy, 1);
        if (!hold) begin
            deal_req = 1'b0;
            clk_step();
            check({name, " ack drop"}, deal_ack, 0);
        end
    endtask

    // The only address equal to 4479 is the bottom-right sprite pixel, so this pins pos exactly.
    task automatic probe_corner(input string name, input logic [10:0] x, input logic [10:0] y);
        vin.hcount = x + 11'd55;
        vin.vcount = y + 11'd79;
        #1;
        check(name, pixel_addr, 13'd4479);
    endtask

    task automatic apply_probe(input string name, input probe_t p);
        logic [11:0] exp_rgb;
        vin.hcount = p.h;
        vin.vcount = p.v;
        vin.rgb    = p.bg;
        #1;
        check({name, " addr"}, pixel_addr, p.exp_addr);
        exp_rgb = p.exp_in ? rom_f(p.exp_addr) : p.bg;
        repeat (3) clk_step();
        check({name, " rgb"}, vout.rgb, exp_rgb);
        check({name, " hcount"}, vout.hcount, p.h);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [37:0] hist [12];
        logic [37:0] got;
        logic [11:0] exp_t;
        int nd, acks;

        tbl[0] = '{h: 11'd250, v: 11'd300, bg: 12'h111, exp_addr: 13'd0,    exp_in: 1'b1};
        tbl[1] = '{h: 11'd305, v: 11'd379, bg: 12'h222, exp_addr: 13'd4479, exp_in: 1'b1};
        tbl[2] = '{h: 11'd249, v: 11'd300, bg: 12'h333, exp_addr: 13'd0,    exp_in: 1'b0};
        tbl[3] = '{h: 11'd306, v: 11'd300, bg: 12'h444, exp_addr: 13'd0,    exp_in: 1'b0};
        tbl[4] = '{h: 11'd251, v: 11'd301, bg: 12'h555, exp_addr: 13'd57,   exp_in: 1'b1};
        tbl[5] = '{h: 11'd250, v: 11'd380, bg: 12'h666, exp_addr: 13'd0,    exp_in: 1'b0};

        // Reset while active video with nonzero inputs and a pending request
        rst_n      = 1'b0;
        deal_req   = 1'b1;
        target_x   = 11'd100;
        target_y   = 11'd365;
        vin.hcount = 11'd123;
        vin.vcount = 11'd45;
        vin.hsync  = 1'b1;
        vin.vsync  = 1'b1;
        vin.hblnk  = 1'b1;
        vin.vblnk  = 1'b0;
        vin.rgb    = 12'hFFF;
        repeat (5) clk_step();
        got = {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};
        check("reset vga_out", got, 0);
        check("reset pixel_addr", pixel_addr, 0);
        check("reset deal_ack", deal_ack, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        deal_req = 1'b0;
        rst_n    = 1'b1;

        // Pass-through latency in IDLE: every field delayed by exactly 3 clocks
        for (int k = 0; k < 12; k++) begin
            clk_step();
            if (k >= 3) begin
                got = {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};
                check($sformatf("latency k=%0d", k), got, hist[k-3]);
            end
            vin.hcount = 11'(k * 7 + 3);
            vin.vcount = 11'(k + 300);
            vin.hsync  = k[0];
            vin.vsync  = k[1];
            vin.hblnk  = k[2];
            vin.vblnk  = k[2];
            vin.rgb    = 12'(k * 12'h111);
            hist[k]    = {vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk, vin.rgb};
            #1;
            check($sformatf("idle addr k=%0d", k), pixel_addr, 0);
        end
        vin.vblnk = 1'b0;
        clk_step();

        // Horizontal deal: 152 px at 4 px/frame
        start_deal("horiz", 11'd100, 11'd365, 1'b0);
        ticks(1, nd);
        probe_corner("horiz pos tick1", 11'd248, 11'd365);
        ticks(37, nd);
        check("horiz no early done", nd, 0);
        probe_corner("horiz landed", 11'd100, 11'd365);
        check("horiz busy in LAND", busy, 1);
        ticks(1, nd);
        check("horiz done tick39", nd, 1);
        check("horiz busy after", busy, 0);

        // Diagonal uneven deal: x arrives after 1 tick, y after 17
        start_deal("diag", 11'd250, 11'd300, 1'b0);
        ticks(1, nd);
        probe_corner("diag pos tick1", 11'd250, 11'd361);
        ticks(16, nd);
        check("diag no early done", nd, 0);
        for (int i = 0; i < 6; i++) apply_probe($sformatf("diag vec%0d", i), tbl[i]);
        ticks(1, nd);
        check("diag done tick18", nd, 1);

        // Requests during MOVE are ignored
        start_deal("reject", 11'd240, 11'd365, 1'b0);
        ticks(1, nd);
        deal_req = 1'b1;
        target_x = 11'd0;
        target_y = 11'd0;
        acks = 0;
        repeat (3) begin
            clk_step();
            if (deal_ack) acks++;
        end
        deal_req = 1'b0;
        check("reject no ack", acks, 0);
        ticks(2, nd);
        check("reject no early done", nd, 0);
        probe_corner("reject path kept", 11'd240, 11'd365);
        ticks(1, nd);
        check("reject done", nd, 1);

        // Off-screen target is clamped to (584,400)
        start_deal("clamp", 11'd700, 11'd470, 1'b0);
        ticks(83, nd);
        check("clamp no early done", nd, 0);
        probe_corner("clamp landed", 11'd584, 11'd400);
        ticks(1, nd);
        check("clamp done", nd, 1);

        // Target at deck with deal_req held: LAND on tick 1, done on tick 2, re-accept next cycle
        start_deal("deck", 11'd252, 11'd365, 1'b1);
        ticks(1, nd);
        check("deck no done tick1", nd, 0);
        probe_corner("deck landed", 11'd252, 11'd365);
        vin.vblnk = 1'b1;
        clk_step();
        check("deck done tick2", done, 1);
        check("deck no ack with done", deal_ack, 0);
        vin.vblnk = 1'b0;
        clk_step();
        check("deck re-accept ack", deal_ack, 1);
        check("deck re-accept busy", busy, 1);
        deal_req = 1'b0;
        ticks(2, nd);
        check("deck second done", nd, 1);

        // Reset mid-MOVE at tick 10
        start_deal("midrst", 11'd100, 11'd365, 1'b0);
        ticks(10, nd);
        rst_n = 1'b0;
        #1;
        check("midrst busy", busy, 0);
        clk_step();
        check("midrst done", done, 0);
        check("midrst rgb cleared", vout.rgb, 0);
        rst_n = 1'b1;
        clk_step();
        ticks(3, nd);
        check("midrst no done after", nd, 0);
        apply_probe("midrst no sprite", '{h: 11'd215, v: 11'd370, bg: 12'h123, exp_addr: 13'd0, exp_in: 1'b0});

        // Transparent colour handling
        start_deal("transp", 11'd252, 11'd365, 1'b0);
        ticks(1, nd);
        rom_force  = 1'b1;
        vin.hcount = 11'd260;
        vin.vcount = 11'd370;
        vin.rgb    = 12'h0A0;
        #1;
        check("transp addr", pixel_addr, 13'd288);
        repeat (3) clk_step();
`ifdef CARD_ANIM_TRANSPARENT_EN
        exp_t = 12'h0A0;
`else
        exp_t = 12'hF0F;
`endif
        check("transp rgb", vout.rgb, exp_t);
        rom_force = 1'b0;
        ticks(1, nd);
        check("transp done", nd, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
